// File: rtl/digit_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_scanner_pkg
// Brief    : Shared types and constants for the multiplexed 7-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
package digit_scanner_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int          NUM_DIGITS = 4;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [1:0] idx);
        anode_sel_n = ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scanner_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg
// Brief    : Hex nibble to active-low segments {dp, g..a}; dp bit fixed off.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg (
    input  logic [3:0] i_digit,
    output logic [7:0] o_seg_n
);

    always_comb begin
        o_seg_n = 8'hFF;
        case (i_digit)
            4'h0: o_seg_n = 8'hC0;
            4'h1: o_seg_n = 8'hF9;
            4'h2: o_seg_n = 8'hA4;
            4'h3: o_seg_n = 8'hB0;
            4'h4: o_seg_n = 8'h99;
            4'h5: o_seg_n = 8'h92;
            4'h6: o_seg_n = 8'h82;
            4'h7: o_seg_n = 8'hF8;
            4'h8: o_seg_n = 8'h80;
            4'h9: o_seg_n = 8'h90;
            4'hA: o_seg_n = 8'h88;
            4'hB: o_seg_n = 8'h83;
            4'hC: o_seg_n = 8'hC6;
            4'hD: o_seg_n = 8'hA1;
            4'hE: o_seg_n = 8'h86;
            4'hF: o_seg_n = 8'h8E;
            default: o_seg_n = 8'hFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : digit_scanner
// Brief    : 4-digit multiplexed 7-segment driver with frame-synchronous update.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int ON_CYCLES    = 99000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an_n,
    output logic [7:0]  seg_n,
    output logic        frame_tick
);

    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    if (ON_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("digit_scanner: ON_CYCLES and BLANK_CYCLES must both be >= 1");
    end

    scan_state_t       r_state, w_state_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              w_state_done;
    logic              w_frame_end;

    logic [15:0]       r_active_value, r_pend_value;
    logic [3:0]        r_active_blank, r_pend_blank;
    logic [3:0]        r_active_dp,    r_pend_dp;
    logic              r_pend_valid;

    logic [3:0]        r_an_n, w_an_next;
    logic [7:0]        r_seg_n, w_seg_next;
    logic              r_frame_tick;
    logic [3:0]        w_sel_nibble;
    logic [7:0]        w_dec_seg;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt + 1'b1;
        w_state_done = (r_state == BLANK) ? (r_cnt == C_BLANK_LAST)
                                          : (r_cnt == C_ON_LAST);
        w_frame_end  = 1'b0;
        if (w_state_done) begin
            w_cnt_next = '0;
            if (r_state == BLANK) begin
                w_state_next = DRIVE;
            end else begin
                w_state_next = BLANK;
                w_idx_next   = r_idx + 1'b1;
                w_frame_end  = (r_idx == IDX_W'(NUM_DIGITS - 1));
            end
        end
    end

    // ------- double-buffered display data; active only moves at frame end -------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_value <= 16'h0000;
            r_active_blank <= 4'h0;
            r_active_dp    <= 4'h0;
            r_pend_value   <= 16'h0000;
            r_pend_blank   <= 4'h0;
            r_pend_dp      <= 4'h0;
            r_pend_valid   <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_active_value <= value;
                r_active_blank <= blank_mask;
                r_active_dp    <= dp_mask;
            end else if (r_pend_valid) begin
                r_active_value <= r_pend_value;
                r_active_blank <= r_pend_blank;
                r_active_dp    <= r_pend_dp;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_value <= value;
            r_pend_blank <= blank_mask;
            r_pend_dp    <= dp_mask;
            r_pend_valid <= 1'b1;
        end
    end

    // ---------------- output stage ----------------
    assign w_sel_nibble = r_active_value[{r_idx, 2'b00} +: 4];

    seven_seg u_seven_seg (
        .i_digit (w_sel_nibble),
        .o_seg_n (w_dec_seg)
    );

    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        if (r_state == DRIVE && !r_active_blank[r_idx]) begin
            w_an_next  = anode_sel_n(r_idx);
            // Decoder's dp bit is always 1, so AND-ing just substitutes the dp.
            w_seg_next = {w_dec_seg[7] & ~r_active_dp[r_idx], w_dec_seg[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= AN_OFF;
            r_seg_n      <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_an_n       <= w_an_next;
            r_seg_n      <= w_seg_next;
            r_frame_tick <= w_frame_end;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scanner
// Brief    : Scoreboard bench for digit_scanner against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scanner;

    localparam int ON    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = ON + BL;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;
    logic        frame_tick;

    digit_scanner #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  d;
    } load_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       ft;
    } exp_t;

    load_t hist[$];
    exp_t  sb[$];
    exp_t  mon_e;
    int    k = 0;
    int    checks = 0;
    int    errors = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Cycle k after reset shows the scan slot of cycle k-1; a frame shows the
    // last load taken at or before its first cycle.
    function automatic exp_t model(input int kk);
        exp_t        e;
        int          s;
        int          dg;
        int          f;
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  d;
        logic [3:0]  nib;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.ft  = (kk > 0) && (kk % FRAME == 0);
        if (kk >= 1) begin
            s = kk - 1;
            if (s % SLOT >= BL) begin
                dg = (s / SLOT) % 4;
                f  = s / FRAME;
                v  = 16'h0;
                b  = 4'h0;
                d  = 4'h0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i].at <= f * FRAME) begin
                        v = hist[i].v;
                        b = hist[i].b;
                        d = hist[i].d;
                        break;
                    end
                end
                if (!b[dg]) begin
                    nib   = v[dg*4 +: 4];
                    e.an  = ~(4'b0001 << dg);
                    e.seg = {~d[dg], hex_tbl[nib][6:0]};
                end
            end
        end
        return e;
    endfunction

    // Stimulus-side bookkeeping: record loads and push the expected output.
    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0;
            hist.delete();
        end else begin
            k++;
            if (load) hist.push_back(load_t'{k, value, blank_mask, dp_mask});
        end
        sb.push_back(model(k));
    end

    // Monitor: outputs are presented every cycle; compare away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("an_n", 32'(an_n), 32'(mon_e.an));
            chk("seg_n", 32'(seg_n), 32'(mon_e.seg));
            chk("frame_tick", 32'(frame_tick), 32'(mon_e.ft));
        end
        chk("an_n_single_low", 32'($countones(~an_n) <= 1), 32'd1);
        if (an_n == 4'hF) chk("seg_off_when_an_off", 32'(seg_n), 32'hFF);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
        value      = v;
        blank_mask = b;
        dp_mask    = d;
        load       = 1'b1;
        tick();
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while (k % FRAME != ph && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        chk("phase_reached", 32'(k % FRAME), 32'(ph));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Free-running display of zeros for two frames.
        repeat (2 * FRAME + 5) tick();

        // Mid-frame load appears from the next frame only.
        wait_phase(15);
        do_load(16'h1234, 4'h0, 4'h0);
        repeat (FRAME + 50) tick();

        // Two loads in one frame: last wins.
        wait_phase(5);
        do_load(16'hAAAA, 4'h0, 4'h0);
        wait_phase(20);
        do_load(16'hBEEF, 4'h0, 4'h0);
        repeat (FRAME + 50) tick();

        // Load sampled on the frame-boundary edge goes straight to active.
        wait_phase(FRAME - 1);
        do_load(16'h000F, 4'h0, 4'h0);
        repeat (2 * FRAME + 10) tick();

        // Blanked digit 3, decimal point on digit 0.
        wait_phase(10);
        do_load(16'h8888, 4'b1000, 4'b0001);
        repeat (FRAME + 50) tick();

        // Reset during digit-2 drive with a pending load outstanding.
        wait_phase(3);
        do_load(16'h5555, 4'h0, 4'h0);
        wait_phase(25);
        @(posedge clk);
        #6;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an_n", 32'(an_n), 32'hF);
        chk("async_rst_seg_n", 32'(seg_n), 32'hFF);
        chk("async_rst_frame_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        value      = 16'h4321;
        blank_mask = 4'h0;
        dp_mask    = 4'h0;
        load       = 1'b1;
        tick();
        repeat (2 * FRAME + 10) tick();

        // Randomized loads.
        repeat (600) begin
            tick();
            if ($urandom_range(0, 15) == 0) begin
                value      = 16'($urandom);
                blank_mask = 4'($urandom);
                dp_mask    = 4'($urandom);
                load       = 1'b1;
            end
        end
        tick();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 99000, meaning clocks each digit is driven.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, meaning clocks all anodes are off between digits (anti-ghosting).
REQ-003 The block SHALL have port clk, input, width 1: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port value, input, width 16: four hex nibbles, where nibble i (bits 4i+3:4i) is digit i and digit 0 is rightmost.
REQ-006 The block SHALL have port load, input, width 1: a one-cycle strobe that captures value, blank_mask and dp_mask.
REQ-007 The block SHALL have port blank_mask, input, width 4: a 1 in bit i blanks digit i.
REQ-008 The block SHALL have port dp_mask, input, width 4: a 1 in bit i lights the decimal point of digit i.
REQ-009 The block SHALL have port an_n, output, width 4: active-low anode enables, where bit i is digit i.
REQ-010 The block SHALL have port seg_n, output, width 8: active-low cathodes, with bit 7 the dp and bits 6:0 segments g..a.
REQ-011 The block SHALL have port frame_tick, output, width 1: a one-cycle pulse at each frame boundary.

Function
REQ-012 The scan FSM SHALL have two states, BLANK and DRIVE, plus a 2-bit digit index idx and a cycle counter of width $clog2(max(ON_CYCLES,BLANK_CYCLES)).
- BLANK->DRIVE after BLANK_CYCLES clocks; DRIVE->BLANK after ON_CYCLES clocks.
- The counter clears on every transition.
REQ-013 On each DRIVE->BLANK transition, idx SHALL increment modulo 4, with wrap 3->0.
REQ-014 The DRIVE->BLANK transition with idx==3 SHALL be the frame boundary.
- frame_tick SHALL be 1 for exactly that cycle (registered, visible the cycle after the transition edge).
REQ-015 load SHALL be accepted every cycle with no backpressure.
- The captured triple goes to the pending registers and sets pending_valid.
- A later load before the boundary SHALL overwrite pending (last wins).
REQ-016 At the frame boundary, if pending_valid, the active registers SHALL take the pending registers and pending_valid SHALL clear.
- The displayed value SHALL never change mid-frame (no tearing).
REQ-017 If load coincides with the frame boundary cycle, the newly loaded triple SHALL go directly to active, and pending_valid SHALL end 0.
REQ-018 In BLANK, outputs SHALL be an_n=4'b1111 and seg_n=8'hFF.
REQ-019 In DRIVE with digit idx, outputs SHALL be:
- an_n = ~(4'b0001<<idx), or 4'b1111 if active_blank[idx].
- seg_n[6:0] = the decoded active nibble idx.
- seg_n[7] = ~active_dp[idx].
- If the digit is blanked, seg_n SHALL be 8'hFF.
REQ-020 an_n and seg_n SHALL be registered, and SHALL change one clock after the state/idx change that selects them.
- an_n SHALL never have more than one bit low in any cycle.
REQ-021 Counter and idx arithmetic SHALL be unsigned, and the counter SHALL never exceed its terminal count.
REQ-022 ON_CYCLES>=1 and BLANK_CYCLES>=1 SHALL be elaboration-time checked.

Reset
REQ-023 While rst_n=0, all state SHALL clear asynchronously:
- state=BLANK, idx=0, counter=0.
- active/pending value=16'h0000, blank masks=4'h0, dp masks=4'h0, pending_valid=0.
- an_n=4'b1111, seg_n=8'hFF, frame_tick=0.
REQ-024 After rst_n rises, the first DRIVE SHALL begin after BLANK_CYCLES clocks on digit 0, showing "0".
REQ-025 Reset asserted mid-frame SHALL discard pending data, and a load in the deassertion cycle SHALL be captured normally.

Structure
REQ-026 A shared display package SHALL hold:
- the FSM state enum (BLANK, DRIVE);
- constant NUM_DIGITS=4;
- constant SEG_OFF=8'hFF;
- constant AN_OFF=4'b1111.
REQ-027 The block SHALL instantiate one sub-module, seven_seg: the existing hex-to-segment decoder, with a 4-bit digit in and an 8-bit active-low out, bit 7 fixed 1.
- The block SHALL feed it the selected active nibble and overwrite bit 7 with the dp.

Verification
All scenarios use ON_CYCLES=8 and BLANK_CYCLES=2.
REQ-028 Reset release, no load -> an_n=1111 for 2 cycles, then 1110 for 8 cycles with seg_n=8'hC0 ("0", dp off).
- Digits then rotate 1101, 1011, 0111 with blank gaps.
- frame_tick pulses every 40 cycles.
REQ-029 load value=16'h1234 mid-frame -> the current frame is unchanged.
- From the next frame: digit0 seg_n=8'h99 ("4"), digit1 8'hB0 ("3"), digit2 8'hA4 ("2"), digit3 8'hF9 ("1").
REQ-030 Two loads (16'hAAAA, then 16'hBEEF) in one frame -> the next frame shows BEEF only.
- digit0 seg_n=8'h8E ("F"), digit3 8'h83 ("b").
REQ-031 load coinciding with the frame-boundary cycle, with value=16'h000F -> the very next frame shows F on digit0, and pending_valid=0 afterward.
REQ-032 blank_mask=4'b1000 and dp_mask=4'b0001 -> digit3 slot has an_n=1111 and seg_n=FF.
- digit0 seg_n bit7=0.
- Assertion: an_n never has two low bits, and seg_n=FF whenever an_n=1111.
REQ-033 rst_n dropped during digit 2 DRIVE with pending loaded -> outputs go to the off state immediately (asynchronously).
- After release, the display shows 0000 and the pending value is discarded.
